// File: rtl/ones_cksum_checker.sv
// Receive-side ones'-complement checksum checker over a valid/ready framed stream.
// Optional CKSUM_POS_ZERO_EN: also pass on an all-zeros final sum.
module ones_cksum_checker #(
    parameter int WIDTH     = 4,
    parameter int MAX_WORDS = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             valid,
    input  logic             last,
    output logic             ready,
    output logic             done,
    output logic             pass,
    output logic             len_err,
    output logic [WIDTH-1:0] sum
);

    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH:0]   w_add;
    logic [WIDTH-1:0] w_acc_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_overrun;
    logic             w_end;
    logic             w_sum_good;

    assign w_accept = valid & ready;

    // A new frame starts from zero so it never inherits the previous sum.
    assign w_base     = (r_state == S_IDLE) ? '0 : r_acc;
    assign w_add      = {1'b0, w_base} + {1'b0, din};
    assign w_acc_next = w_add[WIDTH-1:0] + WIDTH'(w_add[WIDTH]);

    assign w_cnt_next = (r_state == S_IDLE) ? CW'(1) : r_count + CW'(1);
    assign w_overrun  = (r_state == S_ACCUM) & ~last
                      & (w_cnt_next == CW'(MAX_WORDS));
    assign w_end      = w_accept & (last | w_overrun);

`ifdef CKSUM_POS_ZERO_EN
    assign w_sum_good = (&w_acc_next) | (w_acc_next == '0);
`else
    assign w_sum_good = &w_acc_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = last ? S_RESULT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_end) begin
                    w_next = S_RESULT;
                end
            end
            S_RESULT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state != S_RESULT);
        done  = (r_state == S_RESULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= w_cnt_next;
        end
    end

    // Results hold until the next frame's first word is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass    <= 1'b0;
            len_err <= 1'b0;
            sum     <= '0;
        end else if (w_end) begin
            pass    <= w_sum_good & ~w_overrun;
            len_err <= w_overrun;
            sum     <= w_acc_next;
        end else if (w_accept && r_state == S_IDLE) begin
            pass    <= 1'b0;
            len_err <= 1'b0;
            sum     <= '0;
        end
    end

endmodule

// File: tb/tb_ones_cksum_checker.sv
// Self-checking bench for ones_cksum_checker: directed frames plus random
// frames against an arithmetic ones'-complement model.
module tb_ones_cksum_checker;

    localparam int MAXW = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       valid;
    logic       last;
    logic       ready;
    logic       done;
    logic       pass;
    logic       len_err;
    logic [3:0] sum;

    int n_cmp = 0;
    int n_err = 0;
    int w[16];

    ones_cksum_checker #(.WIDTH(4), .MAX_WORDS(MAXW)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .valid   (valid),
        .last    (last),
        .ready   (ready),
        .done    (done),
        .pass    (pass),
        .len_err (len_err),
        .sum     (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Ones'-complement add with plain integer arithmetic.
    function automatic int oc_add(input int a, input int b);
        int s;
        s = a + b;
        return (s > 15) ? s - 15 : s;
    endfunction

    task automatic expect_frame(input int n, input bit lst,
                                output int es, output int ep, output int el);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s = oc_add(s, w[i]);
        es = s;
        el = (!lst && n == MAXW) ? 1 : 0;
`ifdef CKSUM_POS_ZERO_EN
        ep = ((s == 15 || s == 0) && el == 0) ? 1 : 0;
`else
        ep = (s == 15 && el == 0) ? 1 : 0;
`endif
    endtask

    // Sends w[0..n-1]; last asserted on the final word when lst is set.
    task automatic send_words(input int n, input bit lst, input int gap);
        int budget;
        for (int i = 0; i < n; i++) begin
            din   = 4'(w[i]);
            last  = lst && (i == n - 1);
            valid = 1'b1;
            budget = 0;
            while (!ready && budget < 50) begin
                @(posedge clk);
                #1;
                budget++;
            end
            if (budget >= 50) check("ready_timeout", 0, 1);
            @(posedge clk);
            #1;
            valid = 1'b0;
            last  = 1'b0;
            if (i != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    check("gap_done", int'(done), 0);
                end
            end
        end
    endtask

    task automatic frame(input string tag, input int n, input bit lst,
                         input int gap);
        int es, ep, el;
        expect_frame(n, lst, es, ep, el);
        send_words(n, lst, gap);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_rdy"}, int'(ready), 0);
        check({tag, "_sum"}, int'(sum), es);
        check({tag, "_pass"}, int'(pass), ep);
        check({tag, "_lerr"}, int'(len_err), el);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done0"}, int'(done), 0);
        check({tag, "_rdy1"}, int'(ready), 1);
    endtask

    initial begin
        int n, s, gap;
        bit lst, good;
        reset = 1'b1;
        din   = '0;
        valid = 1'b0;
        last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_lerr", int'(len_err), 0);
        check("rst_sum", int'(sum), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        w[0] = 3; w[1] = 5; w[2] = 7;
        frame("f357", 3, 1, 0);
        idle_cycle("f357");

        w[0] = 9; w[1] = 8; w[2] = 13;
        frame("f98d", 3, 1, 0);
        idle_cycle("f98d");
        w[0] = 9; w[1] = 8; w[2] = 12;
        frame("f98c", 3, 1, 0);
        idle_cycle("f98c");

        w[0] = 3; w[1] = 5; w[2] = 7;
        frame("gap", 3, 1, 2);
        idle_cycle("gap");

        w[0] = 1; w[1] = 1; w[2] = 1; w[3] = 1;
        frame("ovr", 4, 0, 0);
        // Next frame offered while in RESULT: must wait, old results held.
        din   = 4'd1;
        last  = 1'b0;
        valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_done0", int'(done), 0);
        check("b2b_hold_sum", int'(sum), 4);
        check("b2b_hold_lerr", int'(len_err), 1);
        w[0] = 1; w[1] = 2; w[2] = 12;
        frame("b2b", 3, 1, 0);
        idle_cycle("b2b");

        w[0] = 9; w[1] = 2; w[2] = 4; w[3] = 15;
        frame("lastmax", 4, 1, 0);
        idle_cycle("lastmax");

        w[0] = 6; w[1] = 6;
        send_words(2, 0, 0);
        check("mid_sum_clr", int'(sum), 0);
        reset = 1'b1;
        #1;
        check("arst_rdy", int'(ready), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("arst_done", int'(done), 0);
        check("arst_sum", int'(sum), 0);
        check("arst_pass", int'(pass), 0);
        idle_cycle("arst");
        w[0] = 3; w[1] = 5; w[2] = 7;
        frame("post_rst", 3, 1, 0);
        idle_cycle("post_rst");

        w[0] = 0; w[1] = 0;
        frame("zero", 2, 1, 0);
        idle_cycle("zero");

        w[0] = 15;
        frame("one_f", 1, 1, 0);
        w[0] = 7;
        frame("one_7", 1, 1, 0);
        idle_cycle("one_7");

        for (int k = 0; k < 60; k++) begin
            lst = ($urandom_range(0, 4) != 0);
            n   = lst ? $urandom_range(1, MAXW) : MAXW;
            gap = $urandom_range(0, 2);
            good = ($urandom_range(0, 1) == 1);
            s = 0;
            for (int i = 0; i < n; i++) begin
                w[i] = $urandom_range(0, 15);
                if (good && lst && n > 1 && i == n - 1) w[i] = 15 - s;
                s = oc_add(s, w[i]);
            end
            frame("rnd", n, lst, gap);
            if ($urandom_range(0, 1) == 1) idle_cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
